lamp_dwell_timer: RTL and testbench

//  Upstream pacing stage for the cyclic RGY lamp FSM. Watches the lamp's current
//  one-hot RGY code and emits a one-cycle 'advance' pulse once that colour's dwell

---
 rtl/lamp_pkg.sv | 21 ++
 rtl/lamp_prescaler.sv | 30 +++
 rtl/lamp_dwell_timer.sv | 139 +++++++++++++
 tb/tb_lamp_dwell_timer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared lamp definitions: RGY one-hot light codes, dwell-timer states and a
// one-hot legality helper.
package lamp_pkg;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  typedef enum logic [2:0] {
    LOAD,
    COUNT,
    ADVANCE,
    WAIT_CHG,
    FAULT
  } state_e;

  function automatic logic is_legal_light(input logic [0:2] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/lamp_prescaler.sv
// Enable-gated modulo-PRESCALE counter with synchronous clear; tick_o marks the
// cycle on which the count wraps back to zero.
module lamp_prescaler #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == LAST);
  assign tick_o = en_i & wrap;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= wrap ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/lamp_dwell_timer.sv
// Dwell pacing for the RGY lamp FSM: pulses 'advance' once the current colour's
// dwell has elapsed and flags illegal or stuck light codes. LAMP_PED_REQ_EN adds ped_req.
module lamp_dwell_timer
  import lamp_pkg::*;
#(
  parameter int unsigned PRESCALE     = 10,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned RED_TICKS    = 5,
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [0:2]       light,
`ifdef LAMP_PED_REQ_EN
  input  logic             ped_req,
`endif
  output logic             advance,
  output logic [CNT_W-1:0] remaining,
  output logic             fault
);

  // Truncate to the counter width first, then bump a zero dwell up to one tick.
  function automatic logic [CNT_W-1:0] clamp_ticks(input int unsigned t);
    logic [CNT_W-1:0] tr;
    tr = CNT_W'(t);
    return (tr == '0) ? CNT_W'(1) : tr;
  endfunction

  localparam logic [CNT_W-1:0] RED_T    = clamp_ticks(RED_TICKS);
  localparam logic [CNT_W-1:0] GREEN_T  = clamp_ticks(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_T = clamp_ticks(YELLOW_TICKS);

  localparam int unsigned      WW        = $clog2(2 * PRESCALE);
  localparam logic [WW-1:0]    WAIT_LAST = WW'(2 * PRESCALE - 1);

  function automatic logic [CNT_W-1:0] ticks_for(input logic [0:2] code);
    logic [CNT_W-1:0] t;
    t = YELLOW_T;
    if (code == RED)   t = RED_T;
    if (code == GREEN) t = GREEN_T;
    return t;
  endfunction

  state_e           state_q;
  logic [0:2]       cur_q;
  logic [CNT_W-1:0] remaining_q;
  logic             advance_q;
  logic             fault_q;
  logic [WW-1:0]    wait_q;
  logic             tick;
  logic             ped_cut;

`ifdef LAMP_PED_REQ_EN
  assign ped_cut = ped_req && (cur_q == GREEN);
`else
  assign ped_cut = 1'b0;
`endif

  lamp_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear_i(state_q == LOAD),
    .en_i   (enable && (state_q == COUNT)),
    .tick_o (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD;
      cur_q       <= '0;
      remaining_q <= '0;
      advance_q   <= 1'b0;
      fault_q     <= 1'b0;
      wait_q      <= '0;
    end else begin
      advance_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          cur_q  <= light;
          wait_q <= '0;
          if (is_legal_light(light)) begin
            remaining_q <= ticks_for(light);
            state_q     <= COUNT;
          end else begin
            remaining_q <= '0;
            fault_q     <= 1'b1;
            state_q     <= FAULT;
          end
        end
        COUNT: begin
          // An external colour change abandons the dwell without an advance.
          if (light != cur_q) begin
            state_q <= LOAD;
          end else if (tick && (remaining_q <= CNT_W'(1))) begin
            remaining_q <= '0;
            advance_q   <= 1'b1;
            state_q     <= ADVANCE;
          end else if (ped_cut && (remaining_q > CNT_W'(1))) begin
            remaining_q <= CNT_W'(1);
          end else if (tick) begin
            remaining_q <= remaining_q - CNT_W'(1);
          end
        end
        ADVANCE: begin
          wait_q  <= '0;
          state_q <= WAIT_CHG;
        end
        WAIT_CHG: begin
          if (light != cur_q) begin
            state_q <= LOAD;
          end else if (wait_q == WAIT_LAST) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        FAULT: begin
          fault_q     <= 1'b1;
          remaining_q <= '0;
        end
        default: begin
          fault_q     <= 1'b1;
          remaining_q <= '0;
          state_q     <= FAULT;
        end
      endcase
    end
  end

  assign advance   = advance_q;
  assign remaining = remaining_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_lamp_dwell_timer.sv
// Directed bench for lamp_dwell_timer with PRESCALE=2, RED=3, GREEN=2 (5 when
// LAMP_PED_REQ_EN is defined), YELLOW=1; the bench plays the lamp FSM.
`timescale 1ns/1ps
module tb_lamp_dwell_timer;
  import lamp_pkg::*;

  localparam int unsigned P  = 2;
  localparam int unsigned RT = 3;
  localparam int unsigned YT = 1;
  localparam int unsigned CW = 8;
`ifdef LAMP_PED_REQ_EN
  localparam int unsigned GT = 5;
`else
  localparam int unsigned GT = 2;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [0:2]    light;
`ifdef LAMP_PED_REQ_EN
  logic          ped_req;
`endif
  logic          advance;
  logic [CW-1:0] remaining;
  logic          fault;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  lamp_dwell_timer #(
    .PRESCALE    (P),
    .CNT_W       (CW),
    .RED_TICKS   (RT),
    .GREEN_TICKS (GT),
    .YELLOW_TICKS(YT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .light    (light),
`ifdef LAMP_PED_REQ_EN
    .ped_req  (ped_req),
`endif
    .advance  (advance),
    .remaining(remaining),
    .fault    (fault)
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves reset released at a negedge; the next cycle is spent in LOAD.
  task automatic do_reset(input logic [0:2] code);
    reset  = 1'b1;
    enable = 1'b1;
    light  = code;
`ifdef LAMP_PED_REQ_EN
    ped_req = 1'b0;
`endif
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_adv(input int unsigned max, output int unsigned steps);
    steps = 0;
    do begin
      step(1);
      steps++;
    end while (advance !== 1'b1 && steps < max);
    if (advance !== 1'b1) check("adv_timeout", 32'(advance), 1);
  endtask

  function automatic logic [0:2] next_light(input logic [0:2] code);
    if (code == RED)   return GREEN;
    if (code == GREEN) return YELLOW;
    return RED;
  endfunction

  function automatic int unsigned ticks_of(input logic [0:2] code);
    if (code == RED)   return RT;
    if (code == GREEN) return GT;
    return YT;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned s;

    // 1: reset values, then one RED dwell with remaining stepping down
    reset  = 1'b1;
    enable = 1'b1;
    light  = RED;
`ifdef LAMP_PED_REQ_EN
    ped_req = 1'b0;
`endif
    step(2);
    check("rst_advance", 32'(advance), 0);
    check("rst_remaining", 32'(remaining), 0);
    check("rst_fault", 32'(fault), 0);
    reset = 1'b0;
    for (int unsigned i = 1; i <= RT * P + 1; i++) begin
      step(1);
      check("t1_advance", 32'(advance), (i == RT * P + 1) ? 1 : 0);
      check("t1_remaining", 32'(remaining), (i <= RT * P) ? RT - (i - 1) / P : 0);
    end

    // 2: closed loop; gap = ADVANCE + one WAIT_CHG cycle + LOAD + ticks*P
    for (int unsigned k = 0; k < 9; k++) begin
      light = next_light(light);
      wait_adv(100, s);
      check("t2_gap", s, ticks_of(light) * P + 3);
      check("t2_fault", 32'(fault), 0);
    end

    // 3: freeze mid-tick for 10 cycles
    do_reset(RED);
    step(2);
    enable = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      step(1);
      check("t3_hold_remaining", 32'(remaining), RT);
      check("t3_hold_advance", 32'(advance), 0);
    end
    enable = 1'b1;
    wait_adv(100, s);
    check("t3_advance_at", 2 + 10 + s, RT * P + 1 + 10);

    // 4: illegal code at LOAD, sticky until reset
    do_reset(3'b110);
    step(1);
    check("t4_fault_set", 32'(fault), 1);
    step(3);
    check("t4_fault_held", 32'(fault), 1);
    check("t4_advance", 32'(advance), 0);
    check("t4_remaining", 32'(remaining), 0);
    reset = 1'b1;
    light = RED;
    step(1);
    check("t4_fault_cleared", 32'(fault), 0);
    reset = 1'b0;
    step(1);
    check("t4_reload", 32'(remaining), RT);

    // 5a: light stuck after advance
    do_reset(RED);
    wait_adv(100, s);
    check("t5_first_adv", s, RT * P + 1);
    for (int unsigned i = 0; i < 2 * P; i++) begin
      step(1);
      check("t5_wait_nofault", 32'(fault), 0);
    end
    step(1);
    check("t5_stuck_fault", 32'(fault), 1);
    check("t5_stuck_advance", 32'(advance), 0);

    // 5b: external change to YELLOW mid-RED
    do_reset(RED);
    step(3);
    check("t5_mid_remaining", 32'(remaining), RT - 1);
    light = YELLOW;
    step(1);
    check("t5_chg_advance", 32'(advance), 0);
    step(1);
    check("t5_reload_remaining", 32'(remaining), YT);
    check("t5_reload_advance", 32'(advance), 0);
    wait_adv(100, s);
    check("t5_yellow_adv", s, YT * P);
    check("t5_no_fault", 32'(fault), 0);

`ifdef LAMP_PED_REQ_EN
    // 6: pedestrian request only shortens GREEN
    do_reset(RED);
    step(1);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    check("t6_red_ped", 32'(remaining), RT);
    wait_adv(100, s);
    light = GREEN;
    s = 0;
    do begin
      step(1);
      s++;
    end while (remaining != CW'(GT - 1) && s < 50);
    check("t6_find", 32'(remaining), GT - 1);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    check("t6_ped_remaining", 32'(remaining), 1);
    check("t6_ped_noadv", 32'(advance), 0);
    step(1);
    check("t6_ped_advance", 32'(advance), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
